// File: rtl/serial_lane_scheduler_if.sv
// Source-FIFO and serializer-lane bundle shared by the lane scheduler and its environment.
// A source pop is a one-cycle strobe: the head byte is consumed on the edge that ends that cycle.
interface serial_lane_scheduler_if;
  logic [7:0] src0_data;
  logic       src0_empty;
  logic       src0_pop;
  logic [7:0] src1_data;
  logic       src1_empty;
  logic       src1_pop;
  logic [7:0] ser_data0;
  logic       ser_valid0;
  logic [7:0] ser_data1;
  logic       ser_valid1;

  modport master (
    input  src0_data, src0_empty, src1_data, src1_empty,
    output src0_pop, src1_pop, ser_data0, ser_valid0, ser_data1, ser_valid1
  );

  modport slave (
    output src0_data, src0_empty, src1_data, src1_empty,
    input  src0_pop, src1_pop, ser_data0, ser_valid0, ser_data1, ser_valid1
  );
endinterface

// File: rtl/serial_lane_scheduler.sv
// Two-lane serializer scheduler: link bring-up (COM training) followed by
// round-robin sharing of two byte sources, one byte per lane per frame.
module serial_lane_scheduler #(
  parameter int         BYTE_CYCLES  = 8,
  parameter int         CNT_W        = 3,
  parameter int         TRAIN_FRAMES = 4,
  parameter logic [7:0] COM_SYM      = 8'hBC,
  parameter logic [7:0] IDL_SYM      = 8'h7C
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  serial_lane_scheduler_if.master  bus,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_TRAIN  = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(BYTE_CYCLES - 1);
  localparam logic [7:0]       TRAIN_LAST = 8'(TRAIN_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] slot_cnt;
  logic [7:0]       train_cnt, train_d;
  logic             ptr, ptr_d;
  logic [7:0]       data0_q, data0_d, data1_q, data1_d;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic             pop0, pop1;
  logic             arb;
  logic             boundary;

  assign boundary = (slot_cnt == SLOT_LAST);

  // Every decision is taken in the boundary cycle only, so mid-frame input
  // changes (empty flags, enable) are ignored until the frame ends.
  always_comb begin
    state_d  = state_q;
    train_d  = train_cnt;
    ptr_d    = ptr;
    data0_d  = data0_q;
    data1_d  = data1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    pop0     = 1'b0;
    pop1     = 1'b0;
    arb      = 1'b0;
    if (boundary && !reset) begin
      case (state_q)
        ST_OFF: begin
          valid0_d = 1'b0;
          valid1_d = 1'b0;
          if (enable) begin
            state_d = ST_TRAIN;
            train_d = 8'h00;
            data0_d = COM_SYM;
            data1_d = COM_SYM;
          end else begin
            data0_d = 8'h00;
            data1_d = 8'h00;
          end
        end
        ST_TRAIN: begin
          if (!enable) begin
            state_d  = ST_OFF;
            data0_d  = 8'h00;
            data1_d  = 8'h00;
            valid0_d = 1'b0;
            valid1_d = 1'b0;
          end else if (train_cnt < TRAIN_LAST) begin
            train_d  = train_cnt + 8'h01;
            data0_d  = COM_SYM;
            data1_d  = COM_SYM;
            valid0_d = 1'b0;
            valid1_d = 1'b0;
          end else begin
            state_d = ST_ACTIVE;
            arb     = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!enable) begin
            state_d  = ST_OFF;
            data0_d  = 8'h00;
            data1_d  = 8'h00;
            valid0_d = 1'b0;
            valid1_d = 1'b0;
          end else begin
            arb = 1'b1;
          end
        end
        default: begin
          state_d  = ST_OFF;
          data0_d  = 8'h00;
          data1_d  = 8'h00;
          valid0_d = 1'b0;
          valid1_d = 1'b0;
        end
      endcase

      if (arb) begin
        if (!bus.src0_empty && !bus.src1_empty) begin
          data0_d  = ptr ? bus.src1_data : bus.src0_data;
          data1_d  = ptr ? bus.src0_data : bus.src1_data;
          valid0_d = 1'b1;
          valid1_d = 1'b1;
          pop0     = 1'b1;
          pop1     = 1'b1;
          ptr_d    = ~ptr;
        end else if (!bus.src0_empty) begin
          // A lone source always takes lane 0; priority passes to the other source.
          data0_d  = bus.src0_data;
          valid0_d = 1'b1;
          data1_d  = IDL_SYM;
          valid1_d = 1'b0;
          pop0     = 1'b1;
          ptr_d    = 1'b1;
        end else if (!bus.src1_empty) begin
          data0_d  = bus.src1_data;
          valid0_d = 1'b1;
          data1_d  = IDL_SYM;
          valid1_d = 1'b0;
          pop1     = 1'b1;
          ptr_d    = 1'b0;
        end else begin
          data0_d  = IDL_SYM;
          data1_d  = IDL_SYM;
          valid0_d = 1'b0;
          valid1_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      slot_cnt  <= '0;
      train_cnt <= 8'h00;
      ptr       <= 1'b0;
      data0_q   <= 8'h00;
      data1_q   <= 8'h00;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
    end else begin
      slot_cnt  <= boundary ? '0 : slot_cnt + 1'b1;
      state_q   <= state_d;
      train_cnt <= train_d;
      ptr       <= ptr_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      valid0_q  <= valid0_d;
      valid1_q  <= valid1_d;
    end
  end

  assign bus.src0_pop   = pop0;
  assign bus.src1_pop   = pop1;
  assign bus.ser_data0  = data0_q;
  assign bus.ser_valid0 = valid0_q;
  assign bus.ser_data1  = data1_q;
  assign bus.ser_valid1 = valid1_q;
  assign state          = state_q;

endmodule

// File: tb/tb_serial_lane_scheduler.sv
// Directed bench for serial_lane_scheduler: training sequence, arbitration,
// link disable and mid-frame reset, with show-ahead source FIFOs modelled as queues.
module tb_serial_lane_scheduler;
  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] state;

  serial_lane_scheduler_if bus ();

  serial_lane_scheduler dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .state  (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int cyc;
  int total;
  int passed;
  int failed;
  int pop0_n, pop1_n, pop0_at, pop1_at, bad_pop;

  task automatic refresh();
    bus.src0_empty = (q0.size() == 0);
    bus.src0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
    bus.src1_empty = (q1.size() == 0);
    bus.src1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // Pops are read before the edge that consumes the head byte.
  task automatic next_cycle();
    #1;
    if (bus.src0_pop === 1'b1) begin
      pop0_n++;
      pop0_at = cyc;
      if (q0.size() == 0) bad_pop++;
      else void'(q0.pop_front());
    end
    if (bus.src1_pop === 1'b1) begin
      pop1_n++;
      pop1_at = cyc;
      if (q1.size() == 0) bad_pop++;
      else void'(q1.pop_front());
    end
    @(negedge clk);
    cyc++;
    refresh();
    #1;
  endtask

  task automatic run_to(int target);
    while (cyc < target) next_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    cyc     = 0;
    pop0_n  = 0;
    pop1_n  = 0;
    pop0_at = -1;
    pop1_at = -1;
    refresh();
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_frame(string tag, logic [1:0] st, logic [7:0] d0, logic v0,
                           logic [7:0] d1, logic v1);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".data0"}, 32'(bus.ser_data0), 32'(d0));
    chk({tag, ".valid0"}, 32'(bus.ser_valid0), 32'(v0));
    chk({tag, ".data1"}, 32'(bus.ser_data1), 32'(d1));
    chk({tag, ".valid1"}, 32'(bus.ser_valid1), 32'(v1));
  endtask

  initial begin
    total = 0; passed = 0; failed = 0; bad_pop = 0; cyc = 0;
    reset = 1'b1;
    enable = 1'b0;
    refresh();

    // Run A: training with empty sources, then arbitration patterns.
    enable = 1'b1;
    do_reset();
    chk_frame("a_reset", 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("a_reset.pop0", 32'(bus.src0_pop), 32'd0);
    run_to(7);
    chk("a_c7.state", 32'(state), 32'd0);
    run_to(8);
    chk_frame("a_train_first", 2'b01, 8'hBC, 1'b0, 8'hBC, 1'b0);
    run_to(39);
    chk_frame("a_train_last", 2'b01, 8'hBC, 1'b0, 8'hBC, 1'b0);
    run_to(40);
    chk_frame("a_idle", 2'b10, 8'h7C, 1'b0, 8'h7C, 1'b0);
    run_to(41);
    q0.push_back(8'h11);
    q1.push_back(8'h22);
    refresh();
    run_to(46);
    chk("a_midframe.pop0_n", 32'(pop0_n), 32'd0);
    chk("a_midframe.pop1_n", 32'(pop1_n), 32'd0);
    run_to(47);
    chk("a_c47.pop0", 32'(bus.src0_pop), 32'd1);
    chk("a_c47.pop1", 32'(bus.src1_pop), 32'd1);
    run_to(48);
    chk_frame("a_both", 2'b10, 8'h11, 1'b1, 8'h22, 1'b1);
    chk("a_both.pop0_at", 32'(pop0_at), 32'd47);
    run_to(49);
    q1.push_back(8'h5A);
    refresh();
    run_to(56);
    chk_frame("a_only1", 2'b10, 8'h5A, 1'b1, 8'h7C, 1'b0);
    chk("a_only1.pop0_n", 32'(pop0_n), 32'd1);
    chk("a_only1.pop1_n", 32'(pop1_n), 32'd2);
    chk("a_only1.pop1_at", 32'(pop1_at), 32'd55);
    run_to(57);
    q0.push_back(8'h33);
    q1.push_back(8'h44);
    refresh();
    run_to(64);
    chk_frame("a_after_only1", 2'b10, 8'h33, 1'b1, 8'h44, 1'b1);
    run_to(65);
    q0.push_back(8'h55);
    q1.push_back(8'h66);
    refresh();
    run_to(70);
    chk_frame("a_hold", 2'b10, 8'h33, 1'b1, 8'h44, 1'b1);
    run_to(72);
    chk_frame("a_rr_swap", 2'b10, 8'h66, 1'b1, 8'h55, 1'b1);
    run_to(80);
    chk_frame("a_drained", 2'b10, 8'h7C, 1'b0, 8'h7C, 1'b0);

    // Run B: two full sources at ACTIVE entry, then link disable mid-frame.
    q0.delete();
    q1.delete();
    q0.push_back(8'hA0); q0.push_back(8'hA1);
    q1.push_back(8'hB0); q1.push_back(8'hB1);
    enable = 1'b1;
    do_reset();
    run_to(39);
    chk("b_c39.pop0", 32'(bus.src0_pop), 32'd1);
    run_to(40);
    chk_frame("b_frame40", 2'b10, 8'hA0, 1'b1, 8'hB0, 1'b1);
    run_to(48);
    chk_frame("b_frame48", 2'b10, 8'hB1, 1'b1, 8'hA1, 1'b1);
    chk("b_frame48.pop0_n", 32'(pop0_n), 32'd2);
    chk("b_frame48.pop1_n", 32'(pop1_n), 32'd2);
    chk("b_frame48.pop0_at", 32'(pop0_at), 32'd47);
    chk("b_frame48.pop1_at", 32'(pop1_at), 32'd47);
    run_to(50);
    enable = 1'b0;
    q0.push_back(8'hC0);
    q1.push_back(8'hD0);
    refresh();
    run_to(55);
    chk_frame("b_frame_completes", 2'b10, 8'hB1, 1'b1, 8'hA1, 1'b1);
    chk("b_c55.pop0", 32'(bus.src0_pop), 32'd0);
    chk("b_c55.pop1", 32'(bus.src1_pop), 32'd0);
    run_to(56);
    chk_frame("b_off", 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("b_off.pop0_n", 32'(pop0_n), 32'd2);

    // Run C: reset pulse in the middle of an ACTIVE frame.
    q0.delete();
    q1.delete();
    q0.push_back(8'hE0);
    q1.push_back(8'hF0);
    enable = 1'b1;
    do_reset();
    run_to(44);
    chk_frame("c_before_reset", 2'b10, 8'hE0, 1'b1, 8'hF0, 1'b1);
    reset = 1'b1;
    run_to(45);
    reset = 1'b0;
    chk_frame("c_reset_values", 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("c_reset.pop0", 32'(bus.src0_pop), 32'd0);
    run_to(52);
    chk("c_c52.state", 32'(state), 32'd0);
    run_to(53);
    chk_frame("c_retrain", 2'b01, 8'hBC, 1'b0, 8'hBC, 1'b0);

    chk("pop_while_empty", 32'(bad_pop), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "bench timed out");
  end
endmodule
